// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for the 2:1 data mux with a hold limit; grant and select follow a sampled request by 1 cycle, f follows data by 1 cycle.
// No backpressure: requesters hold their level request until granted, and are forcibly preempted after MAX_HOLD cycles if the other waits.
module mux2_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic I0,
  input  logic I1,
  output logic X,
  output logic gnt0,
  output logic gnt1,
  output logic f,
  output logic f_bar
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GNT0   = 2'd1;
  localparam logic [1:0] S_GNT1   = 2'd2;
  localparam logic [1:0] S_SWITCH = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic             last;
  logic             last_nxt;
  logic             x_nxt;
  logic             in_grant;

  assign in_grant = (state == S_GNT0) || (state == S_GNT1);

  always_comb begin
    state_nxt = state;
    x_nxt     = X;
    last_nxt  = last;
    case (state)
      S_IDLE: begin
        // On a tie, last==1 hands the grant to requester 0.
        if (req0 && (!req1 || last)) begin
          state_nxt = S_GNT0;
          x_nxt     = 1'b0;
        end else if (req1) begin
          state_nxt = S_GNT1;
          x_nxt     = 1'b1;
        end
      end
      S_GNT0: begin
        if (!req0 || (hold_cnt == HOLD_LAST && req1)) begin
          last_nxt = 1'b0;
          if (req1) begin
            state_nxt = S_SWITCH;
            x_nxt     = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_GNT1: begin
        if (!req1 || (hold_cnt == HOLD_LAST && req0)) begin
          last_nxt = 1'b1;
          if (req0) begin
            state_nxt = S_SWITCH;
            x_nxt     = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        // In SWITCH, X already points at the incoming requester.
        if (X ? req1 : req0) begin
          state_nxt = X ? S_GNT1 : S_GNT0;
        end else if (X ? req0 : req1) begin
          state_nxt = X ? S_GNT0 : S_GNT1;
          x_nxt     = ~X;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      X        <= 1'b0;
      last     <= 1'b1;
      hold_cnt <= '0;
      f        <= 1'b0;
    end else begin
      state <= state_nxt;
      X     <= x_nxt;
      last  <= last_nxt;
      if (state_nxt != state) begin
        hold_cnt <= '0;
      end else if (in_grant && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
      if (in_grant) begin
        f <= X ? I1 : I0;
      end
    end
  end

  assign gnt0  = (state == S_GNT0);
  assign gnt1  = (state == S_GNT1);
  assign f_bar = ~f;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed scenarios plus randomized traffic for mux2_rr_arbiter, checked against an ownership-level model.
module tb_mux2_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst, req0, req1, I0, I1;
  logic X, gnt0, gnt1, f, f_bar;
  logic [4:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the mux, whether a turnaround is in progress, how long the owner has held it.
  int   m_owner;
  bit   m_turn;
  int   m_held;
  int   m_last;
  bit   m_sel;
  bit   m_f;

  mux2_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (rst),
    .req0  (req0),
    .req1  (req1),
    .I0    (I0),
    .I1    (I1),
    .X     (X),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .f     (f),
    .f_bar (f_bar)
  );

  always #5 clk = ~clk;

  assign obs = {X, gnt0, gnt1, f, f_bar};

  function automatic logic [4:0] exp_vec();
    return {m_sel, (m_owner == 0), (m_owner == 1), m_f, ~m_f};
  endfunction

  task automatic model_step(input bit rs, input bit r0, input bit r1, input bit d0, input bit d1);
    int n, o, inc, outg;
    bit own_req, oth_req;
    if (rs) begin
      m_owner = -1; m_turn = 0; m_held = 0; m_last = 1; m_sel = 0; m_f = 0;
      return;
    end
    if (m_owner >= 0) m_f = m_sel ? d1 : d0;
    if (m_turn) begin
      inc  = m_sel ? 1 : 0;
      outg = 1 - inc;
      m_turn = 0;
      if ((inc == 1) ? r1 : r0) begin
        m_owner = inc; m_held = 1;
      end else if ((outg == 1) ? r1 : r0) begin
        m_owner = outg; m_sel = (outg == 1); m_held = 1;
      end else begin
        m_owner = -1;
      end
    end else if (m_owner < 0) begin
      if (r0 || r1) begin
        m_owner = (r0 && r1) ? (1 - m_last) : (r1 ? 1 : 0);
        m_sel   = (m_owner == 1);
        m_held  = 1;
      end
    end else begin
      n = m_owner; o = 1 - n;
      own_req = (n == 1) ? r1 : r0;
      oth_req = (o == 1) ? r1 : r0;
      if (!own_req || (m_held >= MAX_HOLD && oth_req)) begin
        m_last  = n;
        m_owner = -1;
        if (oth_req) begin
          m_turn = 1;
          m_sel  = (o == 1);
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input logic rs, input logic r0, input logic r1, input logic d0, input logic d1);
    rst = rs; req0 = r0; req1 = r1; I0 = d0; I1 = d1;
    @(posedge clk);
    model_step(rs, r0, r1, d0, d1);
    #1;
  endtask

  task automatic do_reset(input logic r0, input logic r1);
    step(1'b1, r0, r1, 1'b0, 1'b0);
    step(1'b1, r0, r1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    n_checks++;
    if (obs !== 5'b00001) $display("FAIL reset_state: got %b expected %b", obs, 5'b00001);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (obs !== 5'b00001) $display("FAIL reset_idle[%0d]: got %b expected %b", i, obs, 5'b00001);
      else n_pass++;
    end
  endtask

  task automatic test_single_req0();
    logic [4:0] want [4];
    want[0] = 5'b01001; want[1] = 5'b01010; want[2] = 5'b00010; want[3] = 5'b00010;
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== want[0]) $display("FAIL single_grant: got %b expected %b", obs, want[0]);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== want[1]) $display("FAIL single_data: got %b expected %b", obs, want[1]);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== want[2]) $display("FAIL single_release: got %b expected %b", obs, want[2]);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== want[3]) $display("FAIL single_f_holds: got %b expected %b", obs, want[3]);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [2:0] want;
    int p;
    do_reset(1'b1, 1'b1);
    for (int t = 1; t <= 40; t++) begin
      step(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      p = (t - 1) % 18;
      if (p < 8)       want = 3'b010;
      else if (p == 8) want = 3'b100;
      else if (p < 17) want = 3'b101;
      else             want = 3'b000;
      n_checks++;
      if (obs[4:2] !== want) $display("FAIL rotation_t%0d: got %b expected %b", t, obs[4:2], want);
      else n_pass++;
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL rotation_model_t%0d: got %b expected %b", t, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_no_forced_switch();
    logic d;
    logic [4:0] want;
    do_reset(1'b0, 1'b0);
    for (int t = 1; t <= 30; t++) begin
      d = 1'(t % 2);
      step(1'b0, 1'b0, 1'b1, 1'b0, d);
      want = (t >= 2) ? {3'b101, d, ~d} : 5'b10101;
      n_checks++;
      if (obs !== want) $display("FAIL hold_req1_t%0d: got %b expected %b", t, obs, want);
      else n_pass++;
    end
  endtask

  task automatic test_drop_to_switch();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs[4:2] !== 3'b000) $display("FAIL drop_switch: got %b expected %b", obs[4:2], 3'b000);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs[4:2] !== 3'b010) $display("FAIL drop_to_gnt0: got %b expected %b", obs[4:2], 3'b010);
    else n_pass++;

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (obs !== 5'b00010) $display("FAIL abandon_switch: got %b expected %b", obs, 5'b00010);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs !== 5'b00010) $display("FAIL abandon_idle[%0d]: got %b expected %b", i, obs, 5'b00010);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs !== 5'b10110) $display("FAIL mid_grant_pre: got %b expected %b", obs, 5'b10110);
    else n_pass++;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (obs !== 5'b00001) $display("FAIL mid_grant_reset: got %b expected %b", obs, 5'b00001);
    else n_pass++;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== 5'b01001) $display("FAIL post_reset_tie: got %b expected %b", obs, 5'b01001);
    else n_pass++;
  endtask

  task automatic test_random();
    logic rs, r0, r1;
    do_reset(1'b0, 1'b0);
    for (int t = 0; t < 1500; t++) begin
      rs = ($urandom_range(0, 63) == 0);
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      step(rs, r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL random_t%0d: got %b expected %b", t, obs, exp_vec());
      else n_pass++;
      n_checks++;
      if (gnt0 && gnt1) $display("FAIL random_excl_t%0d: got %b%b expected not both", t, gnt0, gnt1);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; I0 = 1'b0; I1 = 1'b0;
    test_reset();
    test_single_req0();
    test_rotation();
    test_no_forced_switch();
    test_drop_to_switch();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
